// File: rtl/quiz_event_gen.sv
// Quiz responder front-end: synchronizes and debounces raw host buttons and buzzers, runs the answer countdown,
// and emits ordered one-cycle events. Optional build macro: EARLY_BUZZ_LOCKOUT_EN (false-start buzzer lockout).
module quiz_event_gen #(
    parameter int unsigned N_PLAYERS  = 4,
    parameter int unsigned DEB_CYCLES = 4,
    parameter int unsigned TICK_DIV   = 100,
    parameter int unsigned TIME_LIMIT = 20
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 btn_start,
    input  logic                 btn_set,
    input  logic                 btn_timer,
    input  logic                 btn_yes,
    input  logic                 btn_no,
    input  logic                 btn_end,
    input  logic [N_PLAYERS-1:0] buzz,
    output logic                 startgame,
    output logic                 startset,
    output logic                 endset,
    output logic                 starttimer,
    output logic                 stoptime,
    output logic                 endtime,
    output logic                 yes,
    output logic                 no,
    output logic                 endgame,
    output logic [N_PLAYERS-1:0] winner,
    output logic [7:0]           time_left
);
    localparam int unsigned   NI         = 6 + N_PLAYERS;
    localparam int unsigned   PW         = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [7:0]    DEB_LAST   = 8'(DEB_CYCLES - 1);
    localparam logic [7:0]    T_LOAD     = 8'(TIME_LIMIT);

    typedef enum logic [2:0] {IDLE, READY, SET, ARMED, JUDGE} state_t;

    logic [NI-1:0]        raw, sync1_q, sync2_q, deb_q, press;
    logic [NI-1:0][7:0]   cnt_q;
    logic                 h_end, h_start, h_set, h_timer, h_yes, h_no;
    logic [N_PLAYERS-1:0] buzz_press, buzz_ok, first;
    logic                 tick, expire;
    logic [7:0]           tl_dec;

    state_t               state_q;
    logic [8:0]           ev_q;
    logic [N_PLAYERS-1:0] winner_q;
    logic [7:0]           time_left_q;
    logic [PW-1:0]        presc_q;

    assign raw = {buzz, btn_end, btn_no, btn_yes, btn_timer, btn_set, btn_start};

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
            deb_q   <= '0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
            for (int unsigned i = 0; i < NI; i++) begin
                if (sync2_q[i] == deb_q[i]) begin
                    cnt_q[i] <= '0;
                end else if (cnt_q[i] == DEB_LAST) begin
                    deb_q[i] <= sync2_q[i];
                    cnt_q[i] <= '0;
                end else begin
                    cnt_q[i] <= cnt_q[i] + 8'd1;
                end
            end
        end
    end

    // Strobe on the edge where the debounced level is about to rise, so the registered event lands one cycle later.
    always_comb begin
        press = '0;
        for (int unsigned i = 0; i < NI; i++)
            press[i] = sync2_q[i] & ~deb_q[i] & (cnt_q[i] == DEB_LAST);
    end

    assign h_end      = press[5];
    assign h_start    = press[0] & ~h_end;
    assign h_set      = press[1] & ~h_end & ~press[0];
    assign h_timer    = press[2] & ~h_end & ~(|press[1:0]);
    assign h_yes      = press[3] & ~h_end & ~(|press[2:0]);
    assign h_no       = press[4] & ~h_end & ~(|press[3:0]);
    assign buzz_press = press[NI-1:6];

`ifdef EARLY_BUZZ_LOCKOUT_EN
    logic [N_PLAYERS-1:0] lock_q;
    assign buzz_ok = buzz_press & ~lock_q;
`else
    assign buzz_ok = buzz_press;
`endif

    assign first  = buzz_ok & (~buzz_ok + N_PLAYERS'(1));
    assign tick   = (presc_q == PRESC_LAST);
    assign expire = tick && (time_left_q == 8'd1);
    assign tl_dec = (time_left_q == 8'd0) ? 8'd0 : time_left_q - 8'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            ev_q        <= '0;
            winner_q    <= '0;
            time_left_q <= '0;
            presc_q     <= '0;
`ifdef EARLY_BUZZ_LOCKOUT_EN
            lock_q      <= '0;
`endif
        end else begin
            ev_q <= '0;
`ifdef EARLY_BUZZ_LOCKOUT_EN
            if (state_q != ARMED) lock_q <= lock_q | buzz_press;
`endif
            if (h_end && state_q != IDLE) begin
                ev_q[0]     <= 1'b1;
                state_q     <= IDLE;
                winner_q    <= '0;
                time_left_q <= '0;
                presc_q     <= '0;
`ifdef EARLY_BUZZ_LOCKOUT_EN
                lock_q      <= '0;
`endif
            end else begin
                unique case (state_q)
                    IDLE: if (h_start) begin
                        ev_q[8] <= 1'b1;
                        state_q <= READY;
`ifdef EARLY_BUZZ_LOCKOUT_EN
                        lock_q  <= '0;
`endif
                    end
                    READY, JUDGE: begin
                        if (state_q == READY && h_set) begin
                            ev_q[7] <= 1'b1;
                            state_q <= SET;
                        end else if (h_timer) begin
                            ev_q[5]     <= 1'b1;
                            state_q     <= ARMED;
                            time_left_q <= T_LOAD;
                            presc_q     <= '0;
                            winner_q    <= '0;
                        end else if (state_q == JUDGE && h_yes) begin
                            ev_q[2] <= 1'b1;
                            state_q <= READY;
                        end else if (state_q == JUDGE && h_no) begin
                            ev_q[1] <= 1'b1;
                            state_q <= READY;
                        end
                    end
                    SET: if (h_set) begin
                        ev_q[6] <= 1'b1;
                        state_q <= READY;
                    end
                    ARMED: begin
                        // A buzz on the expiry tick still wins; the count is frozen at 0 in that case.
                        if (|first) begin
                            ev_q[4]  <= 1'b1;
                            winner_q <= first;
                            state_q  <= JUDGE;
                            if (expire) time_left_q <= 8'd0;
                        end else if (expire) begin
                            ev_q[3]     <= 1'b1;
                            winner_q    <= '0;
                            time_left_q <= 8'd0;
                            state_q     <= JUDGE;
                        end else begin
                            presc_q <= tick ? '0 : presc_q + PW'(1);
                            if (tick) time_left_q <= tl_dec;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign {startgame, startset, endset, starttimer, stoptime, endtime, yes, no, endgame} = ev_q;
    assign winner    = winner_q;
    assign time_left = time_left_q;
endmodule
